sub_bytes_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 50 +++++
 rtl/sbox_lane.sv | 12 +
 rtl/sub_bytes_iter.sv | 101 ++++++++++
 tb/tb_sub_bytes_iter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type, S-box tables and the substitution FSM encoding.
package aes_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_lane.sv
// Single combinational S-box lane; inv_i selects the inverse table.
module sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       inv_i,
    output logic [7:0] data_o
);

    assign data_o = inv_i ? INV_SBOX[data_i] : SBOX[data_i];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES (Inv)SubBytes: LANES S-boxes sweep the latched state chunk by chunk.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned STATE_BYTES = 16,
    parameter int unsigned LANES       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*STATE_BYTES-1:0] in_data,
    input  logic                     in_inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*STATE_BYTES-1:0] out_data,
    output logic                     busy
);

    localparam int unsigned NChunk = STATE_BYTES / LANES;
    localparam int unsigned CntW   = (NChunk > 1) ? $clog2(NChunk) : 1;
    localparam int unsigned ChunkW = 8 * LANES;
    localparam logic [CntW-1:0] LastCnt = CntW'(NChunk - 1);

    if (!((LANES == 1) || (LANES == 2) || (LANES == 4) || (LANES == 8) || (LANES == 16)) ||
        (STATE_BYTES % LANES != 0)) begin : g_param_check
        $error("sub_bytes_iter: illegal STATE_BYTES/LANES combination");
    end

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [8*STATE_BYTES-1:0] data_q, data_d;
    logic                     inv_q, inv_d;
    logic [ChunkW-1:0]        lane_in;
    logic [ChunkW-1:0]        lane_out;

    assign lane_in = data_q[32'(cnt_q) * ChunkW +: ChunkW];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox_lane u_lane (
            .data_i (lane_in[8*l +: 8]),
            .inv_i  (inv_q),
            .data_o (lane_out[8*l +: 8])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        inv_d     = inv_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    inv_d   = in_inv;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Substitute the current chunk in place; other bytes hold their latched value
                data_d[32'(cnt_q) * ChunkW +: ChunkW] = lane_out;
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            inv_q   <= inv_d;
        end
    end

    assign out_data = data_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter: vector table, scoreboard queue and corner sequences.
module tb_sub_bytes_iter;

    localparam int unsigned SB     = 16;
    localparam int unsigned NCHUNK = 4;
    localparam int unsigned W      = 8 * SB;
    localparam int unsigned NVEC   = 6;

    typedef logic [W-1:0] state_t;
    typedef struct {
        state_t data;
        logic   inv;
        state_t want;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   in_valid = 1'b0;
    logic   in_inv = 1'b0;
    logic   out_ready = 1'b1;
    state_t in_data = '0;
    logic   in_ready, out_valid, busy;
    state_t out_data;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int unsigned accept_edge = 0;
    logic        ov_prev = 1'b0;
    logic [7:0]  fwd_tab [256];
    logic [7:0]  inv_tab [256];
    state_t      exp_q [$];
    vec_t        vecs [NVEC];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_bytes_iter #(.STATE_BYTES(SB), .LANES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Extra instances for the lane-count sweep; they share in_data/in_inv only.
    localparam int SW_LANES [4] = '{1, 2, 8, 16};
    logic   sw_valid = 1'b0;
    logic   sw_in_ready [4];
    logic   sw_out_valid [4];
    logic   sw_busy [4];
    state_t sw_out_data [4];

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        sub_bytes_iter #(.STATE_BYTES(SB), .LANES(SW_LANES[g])) u_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sw_valid),
            .in_ready  (sw_in_ready[g]),
            .in_data   (in_data),
            .in_inv    (in_inv),
            .out_valid (sw_out_valid[g]),
            .out_ready (1'b1),
            .out_data  (sw_out_data[g]),
            .busy      (sw_busy[g])
        );
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_tables();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] x;
            logic [7:0] r;
            x = 8'(i);
            r = 8'h01;
            for (int j = 0; j < 254; j++) r = gmul(r, x);
            fwd_tab[i] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
                         {r[3:0], r[7:4]} ^ 8'h63;
        end
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
    endtask

    function automatic state_t model(state_t d, logic inv);
        state_t r;
        for (int k = 0; k < SB; k++)
            r[8*k +: 8] = inv ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
        return r;
    endfunction

    function automatic state_t rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("wait in_ready timeout", in_ready, 1'b1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain outstanding", exp_q.size(), 0);
    endtask

    // Monitor: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) accept_edge <= cyc + 1;
            if (out_valid && !ov_prev) check("latency", cyc - accept_edge, NCHUNK);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected output", out_data, 'x);
                else check("scoreboard", out_data, exp_q.pop_front());
            end
        end
        ov_prev <= out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        state_t d, want, prev_unused;
        int unsigned lat [4];
        int unsigned prev;
        build_tables();

        vecs[0] = '{data: '0, inv: 1'b0, want: {16{8'h63}}};
        vecs[1] = '{data: 128'h0f0e0d0c0b0a09080706050403020100, inv: 1'b0,
                    want: 128'h76abd7fe2b670130c56f6bf27b777c63};
        vecs[2] = '{data: 128'h76abd7fe2b670130c56f6bf27b777c63, inv: 1'b1,
                    want: 128'h0f0e0d0c0b0a09080706050403020100};
        for (int i = 3; i < NVEC; i++) begin
            vecs[i].data = rand_state();
            vecs[i].inv  = 1'(i % 2);
            vecs[i].want = model(vecs[i].data, vecs[i].inv);
        end

        // Reset state
        tick();
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset out_data", out_data, '0);
        rst_n = 1'b1;
        tick();

        // Table vectors through the scoreboard
        for (int i = 0; i < NVEC; i++) begin
            wait_ready();
            in_data  = vecs[i].data;
            in_inv   = vecs[i].inv;
            in_valid = 1'b1;
            exp_q.push_back(vecs[i].want);
            tick();
            in_valid = 1'b0;
            drain(40);
        end

        // Lane sweep: one byte 0x53, rest zero
        in_data = 128'h53;
        in_inv  = 1'b0;
        for (int g = 0; g < 4; g++) begin
            check("sweep in_ready", sw_in_ready[g], 1'b1);
            lat[g] = 0;
        end
        sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            for (int g = 0; g < 4; g++) begin
                if (sw_out_valid[g] && lat[g] == 0) begin
                    lat[g] = k;
                    check("sweep data", sw_out_data[g], {{15{8'h63}}, 8'hed});
                end
            end
        end
        for (int g = 0; g < 4; g++) check("sweep latency", lat[g], 16 / SW_LANES[g]);

        // Backpressure with input churn during RUN
        out_ready = 1'b0;
        d = rand_state();
        want = model(d, 1'b0);
        wait_ready();
        in_data  = d;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        exp_q.push_back(want);
        tick();
        for (int k = 0; k < NCHUNK; k++) begin
            check("run in_ready", in_ready, 1'b0);
            in_data = rand_state();
            in_inv  = ~in_inv;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("bp out_valid", out_valid, 1'b1);
            check("bp in_ready", in_ready, 1'b0);
            check("bp out_data", out_data, want);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp released out_valid", out_valid, 1'b0);
        check("bp released in_ready", in_ready, 1'b1);
        check("bp queue empty", exp_q.size(), 0);

        // Asynchronous reset during RUN with cnt=2
        wait_ready();
        in_data  = rand_state();
        in_inv   = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrun rst in_ready", in_ready, 1'b1);
        check("midrun rst out_valid", out_valid, 1'b0);
        check("midrun rst busy", busy, 1'b0);
        check("midrun rst out_data", out_data, '0);
        tick();
        rst_n = 1'b1;
        d = rand_state();
        wait_ready();
        in_data  = d;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        exp_q.push_back(model(d, 1'b0));
        tick();
        in_valid = 1'b0;
        drain(40);

        // Back-to-back with in_valid held high
        prev = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = rand_state();
            in_data = d;
            in_inv  = 1'($urandom_range(0, 1));
            exp_q.push_back(model(d, in_inv));
            wait_ready();
            tick();
            if (i > 0) check("b2b spacing", cyc - prev, NCHUNK + 2);
            prev = cyc;
        end
        in_valid = 1'b0;
        drain(40);
        prev_unused = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
